// File: rtl/lsu_bridge.sv
// lsu_bridge: load/store bridge between the core memory stage and the data bus.
// Checks alignment, builds byte strobes and replicated write data, runs a
// valid/ready request plus a read-response handshake, and extends load data.
// A saturating timeout counter turns a hung bus into a reported error.
module lsu_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [2:0]  core_funct3,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_stall,
    output logic        core_done,
    output logic [31:0] core_rdata,
    output logic        core_misalign,
    output logic        core_buserr,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t         state;
    logic           we_q;
    logic [2:0]     funct3_q;
    logic [1:0]     addr_lo_q;
    logic [CW-1:0]  cnt;

    logic           req_illegal;
    logic [3:0]     build_strb;
    logic [31:0]    build_wdata;
    logic [7:0]     lane_byte;
    logic [15:0]    lane_half;
    logic [31:0]    load_value;
    logic [CW-1:0]  cnt_inc;
    logic           timed_out;

    // Stall whenever an access is being accepted or is still in flight.
    assign core_stall = (state == IDLE && core_req) || state == REQ || state == WAIT;

    // Decode the incoming request: legality, byte-lane strobes and replicated data.
    always_comb begin
        req_illegal = 1'b0;
        build_strb  = 4'b0000;
        build_wdata = core_wdata;
        case (core_funct3)
            3'b000, 3'b100: begin
                build_strb  = 4'b0001 << core_addr[1:0];
                build_wdata = {4{core_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                build_strb  = core_addr[1] ? 4'b1100 : 4'b0011;
                build_wdata = {2{core_wdata[15:0]}};
                req_illegal = core_addr[0];
            end
            3'b010: begin
                build_strb  = 4'b1111;
                req_illegal = (core_addr[1:0] != 2'b00);
            end
            default: req_illegal = 1'b1;
        endcase
        if (core_we && core_funct3[2]) begin
            req_illegal = 1'b1;
        end
        if (!core_we) begin
            build_strb = 4'b0000;
        end
    end

    // Select the addressed lane of the returned word and sign/zero extend it.
    always_comb begin
        case (addr_lo_q)
            2'd0:    lane_byte = mem_rdata[7:0];
            2'd1:    lane_byte = mem_rdata[15:8];
            2'd2:    lane_byte = mem_rdata[23:16];
            default: lane_byte = mem_rdata[31:24];
        endcase
        lane_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_value = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_value = {24'h000000, lane_byte};
            3'b001:  load_value = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_value = {16'h0000, lane_half};
            default: load_value = mem_rdata;
        endcase
    end

    // Saturating cycle counter; the access times out on the cycle it reaches TIMEOUT.
    always_comb begin
        cnt_inc   = (cnt == TMAX) ? cnt : cnt + CW'(1);
        timed_out = (cnt_inc == TMAX);
    end

    // Main access sequencer with all bus and core outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            funct3_q      <= 3'b000;
            addr_lo_q     <= 2'b00;
            cnt           <= '0;
            core_done     <= 1'b0;
            core_rdata    <= 32'h0;
            core_misalign <= 1'b0;
            core_buserr   <= 1'b0;
            mem_valid     <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 32'h0;
            mem_wstrb     <= 4'b0000;
            mem_wdata     <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (core_req) begin
                        we_q      <= core_we;
                        funct3_q  <= core_funct3;
                        addr_lo_q <= core_addr[1:0];
                        cnt       <= '0;
                        if (req_illegal) begin
                            state         <= DONE;
                            core_done     <= 1'b1;
                            core_misalign <= 1'b1;
                            core_rdata    <= 32'h0;
                        end else begin
                            state     <= REQ;
                            mem_valid <= 1'b1;
                            mem_we    <= core_we;
                            mem_addr  <= {core_addr[31:2], 2'b00};
                            mem_wstrb <= build_strb;
                            mem_wdata <= build_wdata;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt_inc;
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (we_q) begin
                            state     <= DONE;
                            core_done <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (timed_out) begin
                        mem_valid   <= 1'b0;
                        state       <= DONE;
                        core_done   <= 1'b1;
                        core_buserr <= 1'b1;
                        core_rdata  <= 32'h0;
                    end
                end
                WAIT: begin
                    cnt <= cnt_inc;
                    if (mem_rvalid) begin
                        state      <= DONE;
                        core_done  <= 1'b1;
                        core_rdata <= load_value;
                    end else if (timed_out) begin
                        state       <= DONE;
                        core_done   <= 1'b1;
                        core_buserr <= 1'b1;
                        core_rdata  <= 32'h0;
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    core_done     <= 1'b0;
                    core_misalign <= 1'b0;
                    core_buserr   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bridge.sv
// tb_lsu_bridge: directed stimulus with a scoreboard; expected bus requests and
// completions are queued when an access is issued and popped by a monitor.
module tb_lsu_bridge;

    logic        clk;
    logic        rst;
    logic        core_req;
    logic        core_we;
    logic [2:0]  core_funct3;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_stall;
    logic        core_done;
    logic [31:0] core_rdata;
    logic        core_misalign;
    logic        core_buserr;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        chkw;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        berr;
    } resp_t;

    req_t  reqq[$];
    resp_t respq[$];
    int    checks = 0;
    int    errors = 0;

    lsu_bridge #(.TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .core_req      (core_req),
        .core_we       (core_we),
        .core_funct3   (core_funct3),
        .core_addr     (core_addr),
        .core_wdata    (core_wdata),
        .core_stall    (core_stall),
        .core_done     (core_done),
        .core_rdata    (core_rdata),
        .core_misalign (core_misalign),
        .core_buserr   (core_buserr),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wstrb     (mem_wstrb),
        .mem_wdata     (mem_wdata),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if something hangs beyond any reasonable run length.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic void pushReq(input logic [31:0] addr, input logic we, input logic [3:0] strb,
                                    input logic [31:0] wdata, input logic chkw);
        req_t r;
        r.addr = addr; r.we = we; r.strb = strb; r.wdata = wdata; r.chkw = chkw;
        reqq.push_back(r);
    endfunction

    function automatic void pushResp(input logic [31:0] rdata, input logic mis, input logic berr);
        resp_t r;
        r.rdata = rdata; r.mis = mis; r.berr = berr;
        respq.push_back(r);
    endfunction

    // Drive one request for cycle 0 and leave the bench at cycle 1 (+1 ns).
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        core_req    = 1'b1;
        core_we     = we;
        core_funct3 = f3;
        core_addr   = addr;
        core_wdata  = wdata;
        #1;
        checkOutput("stall on request", {31'b0, core_stall}, 32'd1);
        @(posedge clk); #1;
        core_req    = 1'b0;
        core_we     = 1'b0;
        core_funct3 = 3'b000;
        core_addr   = 32'h0;
        core_wdata  = 32'h0;
    endtask

    // Wait (bounded) for the done pulse, then step into the following IDLE cycle.
    task automatic waitDone(input int maxc);
        int n = 0;
        while (!core_done && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("done within bound", {31'b0, core_done}, 32'd1);
        @(posedge clk); #1;
    endtask

    // Monitor: compare every bus handshake and every completion against the queues.
    always @(negedge clk) begin
        if (rst) begin
            if (mem_valid && mem_ready) begin
                if (reqq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected request: got addr %h expected none", mem_addr);
                end else begin
                    req_t e;
                    e = reqq.pop_front();
                    checkOutput("req addr", mem_addr, e.addr);
                    checkOutput("req we", {31'b0, mem_we}, {31'b0, e.we});
                    checkOutput("req strb", {28'b0, mem_wstrb}, {28'b0, e.strb});
                    if (e.chkw) checkOutput("req wdata", mem_wdata, e.wdata);
                end
            end
            if (core_done) begin
                if (respq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected done: got 1 expected 0");
                end else begin
                    resp_t e;
                    e = respq.pop_front();
                    checkOutput("done rdata", core_rdata, e.rdata);
                    checkOutput("done misalign", {31'b0, core_misalign}, {31'b0, e.mis});
                    checkOutput("done buserr", {31'b0, core_buserr}, {31'b0, e.berr});
                end
            end
        end
    end

    initial begin
        rst         = 1'b0;
        core_req    = 1'b0;
        core_we     = 1'b0;
        core_funct3 = 3'b000;
        core_addr   = 32'h0;
        core_wdata  = 32'h0;
        mem_ready   = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset done", {31'b0, core_done}, 32'd0);
        checkOutput("reset valid", {31'b0, mem_valid}, 32'd0);
        checkOutput("reset rdata", core_rdata, 32'h0);
        checkOutput("reset strb", {28'b0, mem_wstrb}, 32'd0);
        checkOutput("reset stall", {31'b0, core_stall}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // SW zero wait
        $display("[TB] SW zero wait");
        mem_ready = 1'b1;
        pushReq(32'h100, 1'b1, 4'b1111, 32'hDEADBEEF, 1'b1);
        pushResp(32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        checkOutput("sw c1 valid", {31'b0, mem_valid}, 32'd1);
        checkOutput("sw c1 addr", mem_addr, 32'h100);
        checkOutput("sw c1 strb", {28'b0, mem_wstrb}, 32'hF);
        @(posedge clk); #1;
        checkOutput("sw c2 done", {31'b0, core_done}, 32'd1);
        checkOutput("sw c2 stall", {31'b0, core_stall}, 32'd0);
        checkOutput("sw c2 valid", {31'b0, mem_valid}, 32'd0);
        @(posedge clk); #1;

        // SB lane 3 with ready held low
        $display("[TB] SB lane 3 backpressure");
        mem_ready = 1'b0;
        pushReq(32'h100, 1'b1, 4'b1000, 32'hA5A5A5A5, 1'b1);
        pushResp(32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'b000, 32'h103, 32'h000000A5);
        for (int k = 0; k < 3; k++) begin
            checkOutput("sb hold valid", {31'b0, mem_valid}, 32'd1);
            checkOutput("sb hold wdata", mem_wdata, 32'hA5A5A5A5);
            checkOutput("sb hold strb", {28'b0, mem_wstrb}, 32'h8);
            checkOutput("sb hold addr", mem_addr, 32'h100);
            checkOutput("sb hold stall", {31'b0, core_stall}, 32'd1);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        waitDone(10);

        // LB with latency check
        $display("[TB] LB / LBU");
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12F03456;
        pushReq(32'h200, 1'b0, 4'b0000, 32'h0, 1'b0);
        pushResp(32'hFFFFFFF0, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'b000, 32'h202, 32'h0);
        checkOutput("lb c1 valid", {31'b0, mem_valid}, 32'd1);
        @(posedge clk); #1;
        checkOutput("lb c2 valid", {31'b0, mem_valid}, 32'd0);
        checkOutput("lb c2 done", {31'b0, core_done}, 32'd0);
        @(posedge clk); #1;
        checkOutput("lb c3 done", {31'b0, core_done}, 32'd1);
        @(posedge clk); #1;

        pushReq(32'h200, 1'b0, 4'b0000, 32'h0, 1'b0);
        pushResp(32'h000000F0, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'b100, 32'h202, 32'h0);
        waitDone(10);

        // LH / LHU
        $display("[TB] LH / LHU");
        mem_rdata = 32'h80010000;
        pushReq(32'h200, 1'b0, 4'b0000, 32'h0, 1'b0);
        pushResp(32'hFFFF8001, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'b001, 32'h202, 32'h0);
        waitDone(10);
        pushReq(32'h200, 1'b0, 4'b0000, 32'h0, 1'b0);
        pushResp(32'h00008001, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'b101, 32'h202, 32'h0);
        waitDone(10);

        // SH upper half keeps the previous load result
        $display("[TB] SH upper half");
        pushReq(32'h100, 1'b1, 4'b1100, 32'h12341234, 1'b1);
        pushResp(32'h00008001, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'b001, 32'h102, 32'h00001234);
        waitDone(10);

        // Alignment and encoding faults
        $display("[TB] faults");
        pushResp(32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h101, 32'h0);
        checkOutput("lw mis done", {31'b0, core_done}, 32'd1);
        checkOutput("lw mis flag", {31'b0, core_misalign}, 32'd1);
        checkOutput("lw mis valid", {31'b0, mem_valid}, 32'd0);
        checkOutput("lw mis rdata", core_rdata, 32'h0);
        @(posedge clk); #1;
        pushResp(32'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'b001, 32'h3, 32'h5555);
        checkOutput("sh mis done", {31'b0, core_done}, 32'd1);
        checkOutput("sh mis valid", {31'b0, mem_valid}, 32'd0);
        @(posedge clk); #1;
        pushResp(32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'b011, 32'h0, 32'h0);
        checkOutput("ld mis done", {31'b0, core_done}, 32'd1);
        checkOutput("ld mis valid", {31'b0, mem_valid}, 32'd0);
        @(posedge clk); #1;
        pushResp(32'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'b100, 32'h0, 32'h0);
        checkOutput("sbu mis done", {31'b0, core_done}, 32'd1);
        @(posedge clk); #1;

        // LW to give core_rdata a nonzero value
        $display("[TB] LW");
        mem_rdata = 32'hCAFEF00D;
        pushReq(32'h204, 1'b0, 4'b0000, 32'h0, 1'b0);
        pushResp(32'hCAFEF00D, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h204, 32'h0);
        waitDone(10);

        // Timeout with no read response
        $display("[TB] timeout");
        mem_rvalid = 1'b0;
        pushReq(32'h300, 1'b0, 4'b0000, 32'h0, 1'b0);
        pushResp(32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'h300, 32'h0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("to not done", {31'b0, core_done}, 32'd0);
            @(posedge clk); #1;
        end
        checkOutput("to done", {31'b0, core_done}, 32'd1);
        checkOutput("to buserr", {31'b0, core_buserr}, 32'd1);
        checkOutput("to misalign", {31'b0, core_misalign}, 32'd0);
        checkOutput("to rdata", core_rdata, 32'h0);
        @(posedge clk); #1;
        mem_rvalid = 1'b1;
        @(posedge clk); #1;
        checkOutput("late rvalid done", {31'b0, core_done}, 32'd0);
        mem_rvalid = 1'b0;

        // Reset pulse during REQ abandons the access
        $display("[TB] reset mid access");
        mem_ready = 1'b0;
        applyStimulus(1'b1, 3'b010, 32'h400, 32'h11223344);
        checkOutput("rst pre valid", {31'b0, mem_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst valid", {31'b0, mem_valid}, 32'd0);
        checkOutput("rst addr", mem_addr, 32'h0);
        checkOutput("rst strb", {28'b0, mem_wstrb}, 32'd0);
        checkOutput("rst wdata", mem_wdata, 32'h0);
        checkOutput("rst stall", {31'b0, core_stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("rst no done", {31'b0, core_done}, 32'd0);
            @(posedge clk); #1;
        end

        checkOutput("req queue drained", reqq.size(), 32'd0);
        checkOutput("resp queue drained", respq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
